// File: rtl/data_memory_dumper.sv
// Walks data memory 0..MEMORY_DEPTH-1 and streams each word MSB-first as bytes on a valid/ready port.
// Build option: define DUMP_CHECKSUM_EN to append an XOR checksum byte after the last data byte.
module data_memory_dumper #(
    parameter int NB_ADDR      = 5,
    parameter int NB_DATA      = 32,
    parameter int MEMORY_DEPTH = 32,
    parameter int NB_BYTE      = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    output logic               o_mem_enable,
    output logic               o_mem_read,
    output logic [NB_ADDR-1:0] o_mem_addr,
    input  logic [NB_DATA-1:0] i_mem_data,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int NB_WORD_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_BCNT       = (NB_WORD_BYTES > 1) ? $clog2(NB_WORD_BYTES) : 1;

    localparam logic [NB_ADDR-1:0] LAST_WORD = NB_ADDR'(MEMORY_DEPTH - 1);
    localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_WORD_BYTES - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_READ     = 3'd1;
    localparam logic [2:0] ST_LATCH    = 3'd2;
    localparam logic [2:0] ST_SEND     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
`ifdef DUMP_CHECKSUM_EN
    localparam logic [2:0] ST_CHECKSUM = 3'd5;
`endif

    logic [2:0]         state_q, state_d;
    logic [NB_ADDR-1:0] word_cnt_q, word_cnt_d;
    logic [NB_BCNT-1:0] byte_cnt_q, byte_cnt_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic               tx_fire;

`ifdef DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum_q, csum_d;
`endif

    assign tx_fire = o_tx_valid && i_tx_ready;

    // Moore outputs; the address bus simply mirrors the word counter so it holds after a dump.
    always_comb begin
        o_mem_enable = (state_q == ST_READ);
        o_mem_read   = (state_q == ST_READ);
        o_mem_addr   = word_cnt_q;
        o_busy       = (state_q != ST_IDLE);
        o_done       = (state_q == ST_DONE);
        o_tx_valid   = 1'b0;
        o_tx_data    = '0;
        if (state_q == ST_SEND) begin
            o_tx_valid = 1'b1;
            o_tx_data  = shift_q[NB_DATA-1 -: NB_BYTE];
        end
`ifdef DUMP_CHECKSUM_EN
        if (state_q == ST_CHECKSUM) begin
            o_tx_valid = 1'b1;
            o_tx_data  = csum_q;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_READ;
                    word_cnt_d = '0;
`ifdef DUMP_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_READ: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                shift_d    = i_mem_data;
                byte_cnt_d = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (tx_fire) begin
                    shift_d    = shift_q << NB_BYTE;
                    byte_cnt_d = byte_cnt_q + NB_BCNT'(1);
`ifdef DUMP_CHECKSUM_EN
                    csum_d     = csum_q ^ o_tx_data;
`endif
                    // Compare before incrementing so the word counter never wraps.
                    if (byte_cnt_q == LAST_BYTE) begin
                        if (word_cnt_q == LAST_WORD) begin
`ifdef DUMP_CHECKSUM_EN
                            state_d = ST_CHECKSUM;
`else
                            state_d = ST_DONE;
`endif
                        end else begin
                            word_cnt_d = word_cnt_q + NB_ADDR'(1);
                            state_d    = ST_READ;
                        end
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CHECKSUM: begin
                if (tx_fire) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
`ifdef DUMP_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_data_memory_dumper.sv
// Bench for data_memory_dumper: memory model, stream monitor and per-scenario tasks against a byte-list reference.
module tb_data_memory_dumper;

    localparam int DEPTH  = 32;
    localparam int NBYTES = 4;
`ifdef DUMP_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_tx_ready = 1'b0;
    logic        o_mem_enable, o_mem_read, o_tx_valid, o_busy, o_done;
    logic [4:0]  o_mem_addr;
    logic [7:0]  o_tx_data;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] rx_byte_q[$];
    int         rx_cyc_q[$];
    int         rd_addr_q[$];
    int         rd_cyc_q[$];
    int         done_cyc_q[$];
    logic [7:0] exp_q[$];

    data_memory_dumper dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .o_mem_enable(o_mem_enable),
        .o_mem_read  (o_mem_read),
        .o_mem_addr  (o_mem_addr),
        .i_mem_data  (mem_rdata),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_clock = ~i_clock;

    // Data memory with a registered read port.
    always @(posedge i_clock) begin
        if (o_mem_enable && o_mem_read) mem_rdata <= mem[o_mem_addr];
    end

    // Monitor: each record carries the index of the cycle that ended at this edge.
    always @(posedge i_clock) begin
        if (o_tx_valid === 1'b1 && i_tx_ready === 1'b1) begin
            rx_byte_q.push_back(o_tx_data);
            rx_cyc_q.push_back(cyc);
        end
        if (o_mem_enable === 1'b1 && o_mem_read === 1'b1) begin
            rd_addr_q.push_back(int'(o_mem_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (o_done === 1'b1) done_cyc_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    // Reference stream: every word split MSB-first, plus an optional XOR of all data bytes.
    task automatic build_expected();
        logic [7:0] cs;
        logic [7:0] bv;
        cs = '0;
        exp_q.delete();
        for (int n = 0; n < DEPTH; n++) begin
            for (int b = 0; b < NBYTES; b++) begin
                bv = 8'((mem[n] >> (8 * (NBYTES - 1 - b))) & 32'hFF);
                exp_q.push_back(bv);
                cs = cs ^ bv;
            end
        end
        if (CSUM != 0) exp_q.push_back(cs);
    endtask

    task automatic start_pulse(output int start_cyc);
        @(negedge i_clock);
        i_start   = 1'b1;
        start_cyc = cyc;
        @(negedge i_clock);
        i_start   = 1'b0;
    endtask

    task automatic wait_done(input int done_base, input int mode, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (done_cyc_q.size() > done_base) begin
                timed_out = 1'b0;
                break;
            end
            i_tx_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge i_clock);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_start = 1'b1;
        repeat (2) @(negedge i_clock);
        n_checks += 7;
        if (o_busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        if (o_mem_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b expected 0", o_mem_enable); end
        if (o_mem_read !== 1'b0)   begin n_fail++; $display("FAIL reset_read: got %b expected 0", o_mem_read); end
        if (o_tx_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_tx_valid); end
        if (o_done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b expected 0", o_done); end
        if (o_mem_addr !== 5'd0)   begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", o_mem_addr); end
        if (o_tx_data !== 8'd0)    begin n_fail++; $display("FAIL reset_data: got %0h expected 0", o_tx_data); end
        i_reset = 1'b0;
        i_start = 1'b0;
        repeat (5) @(negedge i_clock);
        n_checks += 3;
        if (o_busy !== 1'b0)          begin n_fail++; $display("FAIL reset_start_busy: got %b expected 0", o_busy); end
        if (rd_addr_q.size() != 0)    begin n_fail++; $display("FAIL reset_start_reads: got %0d expected 0", rd_addr_q.size()); end
        if (done_cyc_q.size() != 0)   begin n_fail++; $display("FAIL reset_start_done: got %0d expected 0", done_cyc_q.size()); end
        $display("reset: idle after reset with start held, busy=%b", o_busy);
    endtask

    task automatic test_full_dump();
        int  sc, rx_base, rd_base, done_base;
        bit  to;
        for (int n = 0; n < DEPTH; n++) mem[n] = 32'h0A0B0C00 + 32'(n);
        build_expected();
        rx_base = rx_byte_q.size(); rd_base = rd_addr_q.size(); done_base = done_cyc_q.size();
        i_tx_ready = 1'b1;
        start_pulse(sc);
        wait_done(done_base, 0, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL full_timeout: got no done expected done"); end
        n_checks++;
        if (rx_byte_q.size() - rx_base != exp_q.size()) begin
            n_fail++; $display("FAIL full_count: got %0d expected %0d", rx_byte_q.size() - rx_base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (rx_byte_q[rx_base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL full_byte[%0d]: got %0h expected %0h", i, rx_byte_q[rx_base+i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (rd_addr_q.size() - rd_base != DEPTH) begin
            n_fail++; $display("FAIL full_reads: got %0d expected %0d", rd_addr_q.size() - rd_base, DEPTH);
        end else begin
            for (int n = 0; n < DEPTH; n++) begin
                n_checks++;
                if (rd_addr_q[rd_base+n] != n) begin
                    n_fail++; $display("FAIL full_addr[%0d]: got %0d expected %0d", n, rd_addr_q[rd_base+n], n);
                end
            end
            n_checks += 2;
            if (rd_cyc_q[rd_base] - sc != 1) begin
                n_fail++; $display("FAIL start_latency: got %0d expected 1", rd_cyc_q[rd_base] - sc);
            end
            if (!to && done_cyc_q[done_base] - rd_cyc_q[rd_base] != 192 + CSUM) begin
                n_fail++; $display("FAIL done_latency: got %0d expected %0d", done_cyc_q[done_base] - rd_cyc_q[rd_base], 192 + CSUM);
            end
        end
        n_checks++;
        if (rx_byte_q.size() > rx_base && rx_cyc_q[rx_base] - sc != 3) begin
            n_fail++; $display("FAIL first_byte_latency: got %0d expected 3", rx_cyc_q[rx_base] - sc);
        end
        n_checks += 2;
        if (o_busy !== 1'b0)     begin n_fail++; $display("FAIL full_idle_busy: got %b expected 0", o_busy); end
        if (o_mem_addr !== 5'd31) begin n_fail++; $display("FAIL full_addr_hold: got %0d expected 31", o_mem_addr); end
        $display("full_dump: %0d bytes, %0d reads", rx_byte_q.size() - rx_base, rd_addr_q.size() - rd_base);
    endtask

    task automatic test_backpressure();
        int         sc, rx_base, done_base, p, stab;
        bit         to, prev_valid, prev_ready;
        logic [7:0] prev_data;
        bit         pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int n = 0; n < DEPTH; n++) mem[n] = $urandom;
        mem[0] = 32'hDEADBEEF;
        build_expected();
        rx_base = rx_byte_q.size(); done_base = done_cyc_q.size();
        i_tx_ready = 1'b0;
        start_pulse(sc);
        p = 0; stab = 0; to = 1'b1; prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
        for (int i = 0; i < 4000; i++) begin
            if (prev_valid && !prev_ready) begin
                n_checks++; stab++;
                if (o_tx_valid !== 1'b1 || o_tx_data !== prev_data) begin
                    n_fail++; $display("FAIL bp_hold: got valid=%b data=%0h expected valid=1 data=%0h", o_tx_valid, o_tx_data, prev_data);
                end
            end
            if (done_cyc_q.size() > done_base) begin to = 1'b0; break; end
            if (o_tx_valid === 1'b1 && p < 7) begin
                i_tx_ready = pat[p]; p++;
            end else begin
                i_tx_ready = 1'($urandom_range(0, 1));
            end
            prev_valid = (o_tx_valid === 1'b1); prev_ready = i_tx_ready; prev_data = o_tx_data;
            @(negedge i_clock);
        end
        n_checks++;
        if (to) begin n_fail++; $display("FAIL bp_timeout: got no done expected done"); end
        n_checks++;
        if (rx_byte_q.size() - rx_base != exp_q.size()) begin
            n_fail++; $display("FAIL bp_count: got %0d expected %0d", rx_byte_q.size() - rx_base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (rx_byte_q[rx_base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL bp_byte[%0d]: got %0h expected %0h", i, rx_byte_q[rx_base+i], exp_q[i]);
                end
            end
        end
        $display("backpressure: %0d bytes, %0d stalled cycles checked", rx_byte_q.size() - rx_base, stab);
    endtask

    task automatic test_restart_ignored();
        int sc, rx_base, rd_base, done_base;
        bit to, pulsed;
        for (int n = 0; n < DEPTH; n++) mem[n] = $urandom;
        build_expected();
        rx_base = rx_byte_q.size(); rd_base = rd_addr_q.size(); done_base = done_cyc_q.size();
        i_tx_ready = 1'b1;
        start_pulse(sc);
        pulsed = 1'b0; to = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (done_cyc_q.size() > done_base) begin to = 1'b0; break; end
            if (!pulsed && rx_byte_q.size() - rx_base == 5 * NBYTES + 1) begin
                i_start = 1'b1; pulsed = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clock);
        end
        i_start = 1'b0;
        repeat (12) @(negedge i_clock);
        n_checks += 4;
        if (to)     begin n_fail++; $display("FAIL restart_timeout: got no done expected done"); end
        if (!pulsed) begin n_fail++; $display("FAIL restart_pulse: got 0 expected 1 start pulses in word 5"); end
        if (done_cyc_q.size() - done_base != 1) begin
            n_fail++; $display("FAIL restart_done_count: got %0d expected 1", done_cyc_q.size() - done_base);
        end
        if (rd_addr_q.size() - rd_base != DEPTH) begin
            n_fail++; $display("FAIL restart_reads: got %0d expected %0d", rd_addr_q.size() - rd_base, DEPTH);
        end
        n_checks++;
        if (rx_byte_q.size() - rx_base != exp_q.size()) begin
            n_fail++; $display("FAIL restart_count: got %0d expected %0d", rx_byte_q.size() - rx_base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (rx_byte_q[rx_base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL restart_byte[%0d]: got %0h expected %0h", i, rx_byte_q[rx_base+i], exp_q[i]);
                end
            end
        end
        $display("restart_ignored: %0d bytes, %0d done pulses", rx_byte_q.size() - rx_base, done_cyc_q.size() - done_base);
    endtask

    task automatic test_reset_mid_dump();
        int sc, rx_base, rd_base, done_base, rx_after;
        bit to, found;
        for (int n = 0; n < DEPTH; n++) mem[n] = $urandom;
        rd_base = rd_addr_q.size(); done_base = done_cyc_q.size();
        i_tx_ready = 1'b1;
        start_pulse(sc);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rd_addr_q.size() - rd_base == 11 && o_tx_valid === 1'b1) begin found = 1'b1; break; end
            @(negedge i_clock);
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL midreset_reach: got 0 expected SEND of word 10"); end
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        n_checks += 4;
        if (o_tx_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", o_tx_valid); end
        if (o_busy !== 1'b0)     begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", o_busy); end
        if (o_done !== 1'b0)     begin n_fail++; $display("FAIL midreset_done: got %b expected 0", o_done); end
        if (o_mem_addr !== 5'd0) begin n_fail++; $display("FAIL midreset_addr: got %0d expected 0", o_mem_addr); end
        rx_after = rx_byte_q.size();
        repeat (10) @(negedge i_clock);
        n_checks += 2;
        if (rx_byte_q.size() != rx_after) begin
            n_fail++; $display("FAIL midreset_bytes: got %0d expected %0d", rx_byte_q.size(), rx_after);
        end
        if (done_cyc_q.size() != done_base) begin
            n_fail++; $display("FAIL midreset_nodone: got %0d expected %0d", done_cyc_q.size(), done_base);
        end
        build_expected();
        rx_base = rx_byte_q.size(); rd_base = rd_addr_q.size(); done_base = done_cyc_q.size();
        start_pulse(sc);
        wait_done(done_base, 1, to);
        n_checks += 3;
        if (to) begin n_fail++; $display("FAIL midreset_restart_timeout: got no done expected done"); end
        if (rd_addr_q.size() - rd_base != DEPTH) begin
            n_fail++; $display("FAIL midreset_restart_reads: got %0d expected %0d", rd_addr_q.size() - rd_base, DEPTH);
        end else if (rd_addr_q[rd_base] != 0) begin
            n_fail++; $display("FAIL midreset_restart_addr: got %0d expected 0", rd_addr_q[rd_base]);
        end
        if (rx_byte_q.size() - rx_base != exp_q.size()) begin
            n_fail++; $display("FAIL midreset_restart_count: got %0d expected %0d", rx_byte_q.size() - rx_base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (rx_byte_q[rx_base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL midreset_byte[%0d]: got %0h expected %0h", i, rx_byte_q[rx_base+i], exp_q[i]);
                end
            end
        end
        $display("reset_mid_dump: restart produced %0d bytes", rx_byte_q.size() - rx_base);
    endtask

`ifdef DUMP_CHECKSUM_EN
    task automatic test_checksum();
        int         sc, rx_base, done_base;
        bit         to;
        logic [7:0] want [2];
        want = '{8'h00, 8'hFF};
        for (int r = 0; r < 2; r++) begin
            for (int n = 0; n < DEPTH; n++) mem[n] = (r == 0) ? 32'h01020304 : 32'h0;
            if (r == 1) mem[0] = 32'hFF000000;
            build_expected();
            rx_base = rx_byte_q.size(); done_base = done_cyc_q.size();
            i_tx_ready = 1'b1;
            start_pulse(sc);
            wait_done(done_base, 1, to);
            n_checks += 2;
            if (to) begin n_fail++; $display("FAIL csum_timeout: got no done expected done"); end
            if (rx_byte_q.size() - rx_base != DEPTH * NBYTES + 1) begin
                n_fail++; $display("FAIL csum_count: got %0d expected %0d", rx_byte_q.size() - rx_base, DEPTH * NBYTES + 1);
            end else begin
                n_checks++;
                if (rx_byte_q[rx_byte_q.size()-1] !== want[r]) begin
                    n_fail++; $display("FAIL csum_byte: got %0h expected %0h", rx_byte_q[rx_byte_q.size()-1], want[r]);
                end
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_checks++;
                    if (rx_byte_q[rx_base+i] !== exp_q[i]) begin
                        n_fail++; $display("FAIL csum_stream[%0d]: got %0h expected %0h", i, rx_byte_q[rx_base+i], exp_q[i]);
                    end
                end
            end
            $display("checksum: run %0d final byte %0h", r, rx_byte_q[rx_byte_q.size()-1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid_dump();
`ifdef DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_dumper.md
# data_memory_dumper

- Debug-path block downstream of the data memory.
- On a start pulse it walks every data-memory word from address 0 to MEMORY_DEPTH-1 through the memory's registered read port.
- It serialises each 32-bit word into bytes, most-significant byte first, onto a valid/ready byte stream that feeds the UART transmitter.
- The debug unit uses it to dump data memory to the host after a program halts.

## Interface
Parameters:
- NB_ADDR, 5, data-memory address width
- NB_DATA, 32, data-memory word width (multiple of 8)
- MEMORY_DEPTH, 32, number of words dumped (≤ 2^NB_ADDR)
- NB_BYTE, 8, stream byte width

Ports:
- i_clock  in  1  clock; single clock domain, everything on posedge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle dump request
- o_mem_enable  out  1  data-memory enable
- o_mem_read  out  1  data-memory read strobe
- o_mem_addr  out  NB_ADDR  data-memory address
- i_mem_data  in  NB_DATA  data-memory registered read data
- o_tx_data  out  NB_BYTE  stream byte
- o_tx_valid  out  1  byte valid
- i_tx_ready  in  1  UART transmitter can accept a byte
- o_busy  out  1  dump in progress
- o_done  out  1  one-cycle pulse when the dump completes

## Operation
FSM states are IDLE, READ, LATCH, SEND and DONE.
- **IDLE:** all outputs low except o_mem_addr, which holds its last value (0 after reset). i_start=1 moves to READ and clears the address counter to 0.
- **READ:** o_mem_enable=1, o_mem_read=1, o_mem_addr=word counter. Always moves to LATCH.
- **LATCH:** enable and read are low, so memory holds its output. Capture i_mem_data into the shift register, clear the byte counter, go to SEND.
- **SEND:**
  - o_tx_valid=1 and o_tx_data = shift register [NB_DATA-1 -: NB_BYTE].
  - A transfer happens on any cycle with o_tx_valid && i_tx_ready. On a transfer, shift left by NB_BYTE and increment the byte counter.
  - After byte NB_DATA/NB_BYTE-1 is transferred:
    - if word counter = MEMORY_DEPTH-1, go to DONE;
    - otherwise increment the word counter and go to READ.
- **DONE:** o_done=1 for one cycle, then IDLE.
- o_busy=1 in every state except IDLE.
- Word counter is NB_ADDR bits and never wraps during a dump: the termination compare is done before the increment.

## Timing
- **Reset:** state IDLE. o_mem_enable, o_mem_read, o_tx_valid, o_busy and o_done are 0. o_mem_addr=0, o_tx_data=0, counters=0.
- **Start latency:** i_start sampled at edge k puts the block in READ during cycle k+1.
- **Memory read:** memory registers read data at the end of READ. LATCH samples it one cycle later.
- **First byte:** valid 3 cycles after the i_start edge.
- **Per-word cost:** 2 cycles overhead plus one cycle per accepted byte. With i_tx_ready held high, the default configuration takes 6 cycles per word and 192 cycles for 32 words, followed by the one-cycle o_done.
- **Backpressure:** while o_tx_valid=1 and i_tx_ready=0, o_tx_data and o_tx_valid hold stable. Valid never drops before the transfer.
- **i_start while busy:** ignored, and no restart occurs.
- **Reset mid-dump:** the reset values above apply on the next edge. No further bytes are produced and o_done does not pulse.
- **i_start and i_reset together:** reset wins.

## Configuration
DUMP_CHECKSUM_EN:
- **Defined:** a running NB_BYTE XOR accumulates every transferred data byte. It is cleared when a dump starts.
  - After the last data byte the FSM enters a CHECKSUM state.
  - In CHECKSUM it presents the accumulator as one extra byte under the same valid/ready rules, then goes to DONE.
  - With i_tx_ready held high the default dump takes 193 cycles.
- **Undefined:** no accumulator and no CHECKSUM state. The stream holds exactly MEMORY_DEPTH·NB_DATA/NB_BYTE bytes.

## Test plan
- **Reset:** after reset, all outputs are 0 and state is IDLE. Assert i_reset together with i_start: nothing happens.
- **Full dump, ready high:** preload memory word n = 32'h0A0B0C00+n. Pulse i_start. Expect:
  - 128 bytes: 0A,0B,0C,00, 0A,0B,0C,01, … 0A,0B,0C,1F;
  - o_mem_addr sequence 0..31, one READ each;
  - o_done 192 cycles after the first READ cycle.
- **Backpressure:** word0=32'hDEADBEEF. Toggle i_tx_ready 1,0,0,1,0,1,1. Expect DE, AD, BE, EF each held stable while ready is low, and no byte lost or duplicated.
- **Restart ignored:** pulse i_start during byte 2 of word 5. The stream is unchanged and there is exactly one o_done.
- **Reset mid-dump:** assert i_reset while in SEND of word 10. The next cycle shows o_tx_valid=0 and o_busy=0, with no o_done. A new i_start restarts from address 0.
- **DUMP_CHECKSUM_EN:** all words 32'h01020304. Expect 128 data bytes plus a final byte 8'h00. With word0 = 32'hFF000000 and the others zero, the final byte is 8'hFF.
